// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states
//   RW_*          : hold codes driven back to the program counter
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ADV  = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

   localparam logic [1:0] RW_ADV  = 2'b00;  // counter increments at this edge
   localparam logic [1:0] RW_HOLD = 2'b01;  // waiting on memory / halted
   localparam logic [1:0] RW_FULL = 2'b10;  // instruction buffer is full

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding {pc, instruction} entries for decode.
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   clear        drop all entries (wins over push and pop)
//   push, wdata  write one entry (ignored when full)
//   pop          remove head entry (ignored when empty)
//   rdata        head entry, all zeros when empty
//   full, empty  occupancy flags
module fetch_buffer #(
   parameter int WIDTH     = 40,
   parameter int BUF_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

   logic [WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [WIDTH-1:0] mem_d [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = next_ptr(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         // simultaneous push and pop leaves occupancy unchanged
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: entries are only visible through count_q
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage sitting after the 8-bit program counter.
// Reads instruction memory at the current pc via a req/ack handshake,
// queues {pc, instruction} for decode, and tells the counter when to advance.
// Ports:
//   clk, reset              clock and synchronous active-low reset
//   pc                      current program counter value
//   rw                      hold code: 00 advance, 01 hold, 10 buffer full
//   mem_req/mem_addr        memory read request and address
//   mem_ack/mem_rdata       memory read completion and data
//   inst_valid/pc/data      FIFO head towards decode
//   inst_ready              decode accepts the head entry
//   flush                   drop buffered and in-flight fetches
//   timeout_err             sticky flag: memory never acknowledged
module instr_fetch_stage
   import fetch_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 2,
   parameter int TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic [1:0]        rw,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [DATA_W-1:0] inst_data,
   input  logic              inst_ready,
   input  logic              flush,
   output logic              timeout_err
);

   localparam int CNT_W   = $clog2(TIMEOUT + 1);
   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                timeout_err_q, timeout_err_d;
   logic                buf_push, buf_pop, buf_clear, buf_full, buf_empty;
   logic [ENTRY_W-1:0]  buf_rdata;

   fetch_buffer #(
      .WIDTH     (ENTRY_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk   (clk),
      .reset (reset),
      .clear (buf_clear),
      .push  (buf_push),
      .wdata ({mem_addr_q, mem_rdata}),
      .pop   (buf_pop),
      .rdata (buf_rdata),
      .full  (buf_full),
      .empty (buf_empty)
   );

   assign inst_valid = ~buf_empty;
   assign inst_pc    = buf_rdata[ENTRY_W-1:DATA_W];
   assign inst_data  = buf_rdata[DATA_W-1:0];
   assign buf_pop    = inst_valid & inst_ready;

   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = timeout_err_q;
      buf_push      = 1'b0;
      buf_clear     = 1'b0;
      // flush beats a same-cycle ack, so the pc is not advanced and the
      // same address is fetched again; HALT ignores flush entirely
      if (flush && state_q != HALT) begin
         buf_clear  = 1'b1;
         wait_cnt_d = '0;
         state_d    = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!buf_full) begin
                  mem_addr_d = pc;
                  state_d    = WAIT;
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  buf_push   = 1'b1;
                  wait_cnt_d = '0;
                  state_d    = ADV;
               end else if (wait_cnt_q == LAST_WAIT) begin
                  timeout_err_d = 1'b1;
                  wait_cnt_d    = '0;
                  state_d       = HALT;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end
            ADV:     state_d = IDLE;
            default: state_d = HALT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         mem_addr_q    <= '0;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_addr_q    <= mem_addr_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      case (state_q)
         IDLE:    rw = buf_full ? RW_FULL : RW_HOLD;
         ADV:     rw = RW_ADV;
         default: rw = RW_HOLD;
      endcase
   end

   assign mem_req     = (state_q == WAIT);
   assign mem_addr    = mem_addr_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  pc;
   logic [1:0]  rw;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [7:0]  inst_pc;
   logic [31:0] inst_data;
   logic        inst_ready;
   logic        flush;
   logic        timeout_err;

   logic        ack_model;
   logic        stray_ack;
   logic        ack_en;
   int          ack_lat;
   logic [7:0]  pc_start;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] data;
   } entry_t;
   entry_t exp_q[$];

   always #5 clk = ~clk;

   assign mem_ack = ack_model | stray_ack;

   instr_fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .rw          (rw),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .inst_valid  (inst_valid),
      .inst_pc     (inst_pc),
      .inst_data   (inst_data),
      .inst_ready  (inst_ready),
      .flush       (flush),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [7:0] p);
      entry_t e;
      e.pc   = p;
      e.data = 32'hA000_0000 + {24'h0, p};
      exp_q.push_back(e);
   endtask

   // program counter model: loads pc_start in reset, increments when rw=00
   initial begin
      logic adv;
      pc = 8'h00;
      forever begin
         @(negedge clk);
         adv = (rw == 2'b00);
         @(posedge clk);
         #1;
         if (!reset) pc = pc_start;
         else if (adv) pc = pc + 8'd1;
      end
   end

   // memory model: ack after ack_lat WAIT cycles, data = A000_0000 + addr
   initial begin
      int cnt;
      cnt       = 0;
      ack_model = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req && ack_en) begin
            ack_model = (cnt == ack_lat - 1);
            cnt++;
         end else begin
            ack_model = 1'b0;
            cnt       = 0;
         end
         mem_rdata = 32'hA000_0000 + {24'h0, mem_addr};
      end
   end

   // scoreboard monitor: every accepted head entry is compared against the queue
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop got pc %0h data %0h want none", inst_pc, inst_data);
            end else begin
               entry_t e;
               e = exp_q.pop_front();
               chk("inst_pc", 40'(inst_pc), 40'(e.pc));
               chk("inst_data", 40'(inst_data), 40'(e.data));
            end
         end
      end
   end

   task automatic do_reset(input logic [7:0] start);
      step(1);
      reset      = 1'b0;
      inst_ready = 1'b0;
      flush      = 1'b0;
      stray_ack  = 1'b0;
      pc_start   = start;
      step(2);
      chk("rst_rw", 40'(rw), 40'(2'b01));
      chk("rst_inst_valid", 40'(inst_valid), 40'd0);
      chk("rst_inst_pc", 40'(inst_pc), 40'd0);
      chk("rst_inst_data", 40'(inst_data), 40'd0);
      chk("rst_mem_req", 40'(mem_req), 40'd0);
      chk("rst_mem_addr", 40'(mem_addr), 40'd0);
      chk("rst_timeout_err", 40'(timeout_err), 40'd0);
      chk("rst_pc_load", 40'(pc), 40'(start));
      reset = 1'b1;
   endtask

   task automatic wait_empty(input string name, input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         step(1);
         n++;
      end
      chk(name, 40'(exp_q.size()), 40'd0);
      exp_q.delete();
      inst_ready = 1'b0;
   endtask

   initial begin
      int n;
      reset      = 1'b0;
      inst_ready = 1'b0;
      flush      = 1'b0;
      stray_ack  = 1'b0;
      ack_en     = 1'b0;
      ack_lat    = 1;
      pc_start   = 8'h00;

      // 1: zero-latency memory, decode always ready
      ack_en  = 1'b1;
      ack_lat = 1;
      do_reset(8'h00);
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(8'(i));
      for (int i = 0; i < 9; i++) begin
         if (i > 0) step(1);
         chk("t1_rw_seq", 40'(rw), (i % 3 == 2) ? 40'd0 : 40'd1);
      end
      wait_empty("t1_drain", 60);

      // 2: decode stalled, buffer fills, then drains and fetch resumes at 2
      do_reset(8'h00);
      step(8);
      chk("t2_rw_full", 40'(rw), 40'(2'b10));
      chk("t2_mem_req", 40'(mem_req), 40'd0);
      chk("t2_pc_hold", 40'(pc), 40'h02);
      chk("t2_head_pc", 40'(inst_pc), 40'h00);
      push_exp(8'h00);
      push_exp(8'h01);
      push_exp(8'h02);
      inst_ready = 1'b1;
      n = 0;
      while (!mem_req && n < 10) begin
         step(1);
         n++;
      end
      chk("t2_refetch_req", 40'(mem_req), 40'd1);
      chk("t2_refetch_addr", 40'(mem_addr), 40'h02);
      wait_empty("t2_drain", 30);

      // 3: memory never acks -> timeout, sticky HALT
      ack_en = 1'b0;
      do_reset(8'h00);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (mem_req) n++;
         else if (n > 0) break;
      end
      chk("t3_wait_cycles", 40'(n), 40'd15);
      chk("t3_timeout_err", 40'(timeout_err), 40'd1);
      chk("t3_rw", 40'(rw), 40'(2'b01));
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      step(3);
      chk("t3_halt_req", 40'(mem_req), 40'd0);
      chk("t3_halt_rw", 40'(rw), 40'(2'b01));
      chk("t3_halt_err", 40'(timeout_err), 40'd1);

      // 4: flush and ack in the same cycle at pc=5
      do_reset(8'h05);
      step(1);
      chk("t4_req", 40'(mem_req), 40'd1);
      flush     = 1'b1;
      stray_ack = 1'b1;
      step(1);
      flush     = 1'b0;
      stray_ack = 1'b0;
      chk("t4_rw_a", 40'(rw), 40'(2'b01));
      chk("t4_valid_a", 40'(inst_valid), 40'd0);
      step(1);
      chk("t4_rw_b", 40'(rw), 40'(2'b01));
      chk("t4_req_b", 40'(mem_req), 40'd1);
      chk("t4_addr", 40'(mem_addr), 40'h05);
      chk("t4_pc", 40'(pc), 40'h05);
      chk("t4_valid_b", 40'(inst_valid), 40'd0);

      // 5: pc wrap FE..01 with two-cycle memory latency
      ack_en  = 1'b1;
      ack_lat = 2;
      do_reset(8'hFE);
      inst_ready = 1'b1;
      push_exp(8'hFE);
      push_exp(8'hFF);
      push_exp(8'h00);
      push_exp(8'h01);
      wait_empty("t5_drain", 80);

      // 6: reset during WAIT, stale ack during reset and in the first IDLE
      ack_en  = 1'b0;
      ack_lat = 1;
      do_reset(8'h07);
      step(1);
      chk("t6_req", 40'(mem_req), 40'd1);
      reset = 1'b0;
      step(1);
      stray_ack = 1'b1;
      step(1);
      chk("t6_req_rst", 40'(mem_req), 40'd0);
      chk("t6_valid_rst", 40'(inst_valid), 40'd0);
      reset = 1'b1;
      step(1);
      stray_ack = 1'b0;
      chk("t6_valid_a", 40'(inst_valid), 40'd0);
      chk("t6_req_a", 40'(mem_req), 40'd1);
      chk("t6_addr", 40'(mem_addr), 40'h07);
      step(2);
      chk("t6_valid_b", 40'(inst_valid), 40'd0);
      chk("t6_err", 40'(timeout_err), 40'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got no finish want finish before 100000ns");
      $fatal(1);
   end

endmodule
